// File: rtl/mat_mult_pkg.sv
// Shared definitions for the matrix-multiplier datapath: product width,
// constant-width helper and the accumulator FSM encoding.
package mat_mult_pkg;

  localparam int unsigned PW = 4;

  // Ceiling log2 usable in constant expressions; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/acc_adder.sv
// AW-bit ripple adder: acc plus a zero-extended PW-bit product, carry-in 0.
module acc_adder
  import mat_mult_pkg::*;
#(
  parameter int unsigned AW = 6
) (
  input  logic [AW-1:0] a,
  input  logic [PW-1:0] b,
  output logic [AW-1:0] sum
);

  logic [AW-1:0] b_ext;
  logic [AW-1:0] carry;

  assign b_ext    = AW'(b);
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < AW - 1; i++) begin : g_bit
    full_add u_fa (
      .a  (a[i]),
      .b  (b_ext[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // AW is sized so the sum never overflows; the top bit needs no carry-out.
  assign sum[AW-1] = a[AW-1] ^ b_ext[AW-1] ^ carry[AW-1];

endmodule

// File: rtl/full_add.sv
// Single-bit full adder cell used by the ripple adders of the datapath.
module full_add (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/mat_dot_accumulator.sv
// Sums N consecutive products into one C[row][col] element and presents the
// results in row-major order through a valid/ready output register.
module mat_dot_accumulator
  import mat_mult_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned M = 4,
  localparam int unsigned AW = PW + clog2(N),
  localparam int unsigned CW = clog2(N),
  localparam int unsigned IW = clog2(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          p_valid,
  output logic          p_ready,
  input  logic [PW-1:0] p_data,
  output logic          r_valid,
  input  logic          r_ready,
  output logic [AW-1:0] r_data,
  output logic [IW-1:0] r_row,
  output logic [IW-1:0] r_col,
  output logic          r_last,
  output logic          busy
);

  acc_state_t    state_q, state_d;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] addend_c;
  logic [AW-1:0] sum_c;
  logic [CW-1:0] term_q;
  logic [IW-1:0] row_q, col_q;
  logic          final_c, accept_c, complete_c, drain_c, elem_last_c, p_ready_c;

  // Term 0 starts a fresh sum, so the adder sees zero instead of the old acc.
  assign addend_c = (term_q == '0) ? '0 : acc_q;

  acc_adder #(.AW(AW)) u_adder (
    .a   (addend_c),
    .b   (p_data),
    .sum (sum_c)
  );

  // Handshake decode and next-state logic.
  always_comb begin
    state_d     = state_q;
    final_c     = (term_q == CW'(N - 1));
    drain_c     = r_valid & r_ready;
    elem_last_c = (row_q == IW'(M - 1)) & (col_q == IW'(M - 1));
    // Only the final term stalls, and only while the output register is stuck.
    p_ready_c   = !rst & !clr & !(final_c & r_valid & !r_ready);
    accept_c    = p_valid & p_ready_c;
    complete_c  = accept_c & final_c;

    case (state_q)
      S_IDLE:  if (accept_c) state_d = S_ACC;
      S_ACC:   if (complete_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (clr) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Partial sum, term counter, element indices and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      term_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_last  <= 1'b0;
    end else if (clr) begin
      acc_q   <= '0;
      term_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_last  <= 1'b0;
    end else begin
      if (accept_c) begin
        acc_q  <= sum_c;
        term_q <= final_c ? '0 : term_q + CW'(1);
      end

      if (complete_c) begin
        r_data  <= sum_c;
        r_row   <= row_q;
        r_col   <= col_q;
        r_last  <= elem_last_c;
        r_valid <= 1'b1;
        if (col_q == IW'(M - 1)) begin
          col_q <= '0;
          row_q <= (row_q == IW'(M - 1)) ? '0 : row_q + IW'(1);
        end else begin
          col_q <= col_q + IW'(1);
        end
      end else if (drain_c) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign p_ready = p_ready_c;
  assign busy    = (state_q == S_ACC) | r_valid;

endmodule
